// File: rtl/lifo_stack.sv
// lifo_stack: LIFO stack with configurable push/pop latency, occupancy, high-water and error flags.
module lifo_stack #(
  parameter int depth           = 2,
  parameter int width           = 1,
  parameter int push_latency    = 0,
  parameter int pop_latency     = 0,
  parameter int high_water_mark = 0,
  localparam int CW = $clog2(depth + 1),
  localparam int AW = depth > 1 ? $clog2(depth) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             pop_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             high_water,
  output logic             err_overflow,
  output logic             err_underflow
);
  logic [width-1:0] mem [depth];
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_ov_q, err_un_q;
  logic inflight, push_ok, pop_ok, we;
  logic [AW-1:0] wa, top;
  assign full          = cnt_q == CW'(depth);
  assign empty         = cnt_q == '0;
  assign count         = cnt_q;
  assign high_water    = high_water_mark != 0 && 32'(cnt_q) >= high_water_mark;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
  assign top           = AW'(cnt_q - 1'b1);
  // simultaneous push and pop is refused on both sides
  assign push_ok = enable & push & ~pop & ~full;
  assign pop_ok  = enable & pop & ~push & ~empty & ~inflight;
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt_q    <= '0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_ov_q <= enable & push & ~push_ok;
      err_un_q <= enable & pop & ~pop_ok;
    end
  always_ff @(posedge clock)
    if (we) mem[wa] <= push_data;
  if (push_latency == 0) begin : g_pw0
    assign inflight = 1'b0;
    assign we       = push_ok;
    assign wa       = AW'(cnt_q);
  end else begin : g_pw
    logic [push_latency-1:0] pv_q;
    logic [AW-1:0] pa_q [push_latency];
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        pv_q <= '0;
        for (int i = 0; i < push_latency; i++) pa_q[i] <= '0;
      end else begin
        pv_q    <= push_latency'({pv_q, push_ok});
        pa_q[0] <= AW'(cnt_q);
        for (int i = 1; i < push_latency; i++) pa_q[i] <= pa_q[i-1];
      end
    assign inflight = |pv_q;
    assign we       = pv_q[push_latency-1];
    assign wa       = pa_q[push_latency-1];
  end
  if (pop_latency == 0) begin : g_pr0
    assign pop_valid = pop_ok;
    assign pop_data  = pop_ok ? mem[top] : '0;
  end else begin : g_pr
    logic [pop_latency-1:0] rv_q;
    logic [width-1:0] rd_q [pop_latency];
    // data stages only move with their valid so the output holds between pops
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        rv_q <= '0;
        for (int i = 0; i < pop_latency; i++) rd_q[i] <= '0;
      end else begin
        rv_q <= pop_latency'({rv_q, pop_ok});
        if (pop_ok) rd_q[0] <= mem[top];
        for (int i = 1; i < pop_latency; i++) if (rv_q[i-1]) rd_q[i] <= rd_q[i-1];
      end
    assign pop_valid = rv_q[pop_latency-1];
    assign pop_data  = rd_q[pop_latency-1];
  end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: random and directed checks of two lifo_stack configurations against an event-wheel model.
module tb_lifo_stack;
  localparam int D = 4;
  localparam int PL [2] = '{0, 2};
  localparam int QL [2] = '{0, 3};
  logic clock = 1'b0, reset = 1'b0, en = 1'b0, pu = 1'b0, po = 1'b0;
  logic [7:0] pdi = '0;
  logic [7:0] pd [2];
  logic [2:0] cnt [2];
  logic [1:0] pv, fl, em, hw, eo, eu;
  int n_chk = 0, n_fail = 0;
  int m_cnt [2];
  logic [7:0] m_mem [2][D];
  bit wp [2][16];
  int wadr [2][16];
  bit rp [2][16];
  logic [7:0] rd [2][16];
  logic [7:0] last_pd [2];
  bit exp_pv [2], e_ov [2], e_un [2];
  int E = 0;

  always #5 clock = ~clock;

  lifo_stack #(.depth(D), .width(8), .push_latency(0), .pop_latency(0), .high_water_mark(3)) u0 (
    .clock(clock), .reset(reset), .enable(en), .push(pu), .push_data(pdi), .pop(po),
    .pop_data(pd[0]), .pop_valid(pv[0]), .full(fl[0]), .empty(em[0]), .count(cnt[0]),
    .high_water(hw[0]), .err_overflow(eo[0]), .err_underflow(eu[0]));
  lifo_stack #(.depth(D), .width(8), .push_latency(2), .pop_latency(3), .high_water_mark(3)) u1 (
    .clock(clock), .reset(reset), .enable(en), .push(pu), .push_data(pdi), .pop(po),
    .pop_data(pd[1]), .pop_valid(pv[1]), .full(fl[1]), .empty(em[1]), .count(cnt[1]),
    .high_water(hw[1]), .err_overflow(eo[1]), .err_underflow(eu[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit infl(input int k);
    for (int s = 0; s < 16; s++) if (wp[k][s]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; last_pd[k] = '0; exp_pv[k] = 0; e_ov[k] = 0; e_un[k] = 0;
      for (int s = 0; s < 16; s++) begin wp[k][s] = 0; rp[k][s] = 0; end
    end
  endtask

  task automatic check_all();
    bit acc;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count%0d", k), 32'(cnt[k]), 32'(m_cnt[k]));
      chk($sformatf("full%0d", k), 32'(fl[k]), 32'(m_cnt[k] == D));
      chk($sformatf("empty%0d", k), 32'(em[k]), 32'(m_cnt[k] == 0));
      chk($sformatf("high_water%0d", k), 32'(hw[k]), 32'(m_cnt[k] >= 3));
      chk($sformatf("err_overflow%0d", k), 32'(eo[k]), 32'(e_ov[k]));
      chk($sformatf("err_underflow%0d", k), 32'(eu[k]), 32'(e_un[k]));
    end
    acc = en && po && !pu && m_cnt[0] != 0 && !infl(0);
    chk("pop_valid0", 32'(pv[0]), 32'(acc));
    chk("pop_data0", 32'(pd[0]), acc ? 32'(m_mem[0][m_cnt[0]-1]) : 32'h0);
    chk("pop_valid1", 32'(pv[1]), 32'(exp_pv[1]));
    chk("pop_data1", 32'(pd[1]), 32'(last_pd[1]));
  endtask

  task automatic step();
    bit pu_ok, po_ok;
    int s;
    E++;
    for (int k = 0; k < 2; k++) begin
      pu_ok = en && pu && !po && m_cnt[k] < D;
      po_ok = en && po && !pu && m_cnt[k] > 0 && !infl(k);
      e_ov[k] = en && pu && !pu_ok;
      e_un[k] = en && po && !po_ok;
      if (po_ok) begin
        if (QL[k] > 0) begin
          s = (E + QL[k] - 1) % 16;
          rp[k][s] = 1; rd[k][s] = m_mem[k][m_cnt[k]-1];
        end
        m_cnt[k]--;
      end
      if (pu_ok) begin
        s = (E + PL[k]) % 16;
        wp[k][s] = 1; wadr[k][s] = m_cnt[k];
        m_cnt[k]++;
      end
      s = E % 16;
      if (wp[k][s]) begin m_mem[k][wadr[k][s]] = pdi; wp[k][s] = 0; end
      exp_pv[k] = rp[k][s];
      if (rp[k][s]) begin last_pd[k] = rd[k][s]; rp[k][s] = 0; end
    end
  endtask

  task automatic cyc(input bit e, input bit a, input bit b, input logic [7:0] d);
    @(negedge clock);
    en = e; pu = a; po = b; pdi = d;
    #1 check_all();
    @(posedge clock);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 8'h00);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    cyc(1, 1, 0, 8'h0A); cyc(1, 1, 0, 8'h0B); cyc(1, 1, 0, 8'h0C);
    idle(3);
    repeat (3) cyc(1, 0, 1, 8'h00);
    idle(4);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 8'h20 + 8'(i));
    idle(3);
    repeat (2) cyc(1, 0, 1, 8'h00);
    idle(4);
    cyc(1, 1, 1, 8'h55);
    idle(3);
    repeat (3) cyc(1, 0, 1, 8'h00);
    idle(4);
    cyc(1, 1, 0, 8'h00); cyc(1, 0, 1, 8'h00); cyc(1, 0, 0, 8'h11); cyc(1, 0, 1, 8'h00);
    idle(5);
    cyc(0, 1, 0, 8'h77); cyc(0, 0, 1, 8'h00);
    idle(2);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    idle(4);
    repeat (3) cyc(1, 1, 0, 8'($urandom));
    idle(3);
    cyc(1, 0, 1, 8'h00);
    @(negedge clock);
    en = 1; pu = 0; po = 1;
    #3 reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_count%0d", k), 32'(cnt[k]), 32'h0);
      chk($sformatf("rst_pop_valid%0d", k), 32'(pv[k]), 32'h0);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    po = 0;
    idle(1);
    repeat (2) cyc(1, 1, 0, 8'($urandom));
    idle(3);
    repeat (3) cyc(1, 0, 1, 8'h00);
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
